mw_add_sequencer: RTL

- Multi-word add/subtract sequencer. It sits directly upstream of the team's parameterised ripple-carry adder (DATA_WIDTH-bit A/B/Ci in, S/Co out) and consumes that adder's result.
- Accepts two NUM_WORDS*DATA_WIDTH operands through a valid/ready handshake.
- Feeds the adder one word per cycle, least-significant word first, chaining the carry through a register.
- Collects the sum words and returns the wide result through a valid/ready handshake.
- The adder itself is external and purely combinational; this block owns all sequencing state.

---
 rtl/mw_add_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mw_add_sequencer.sv
// Multi-word add/subtract sequencer driving an external combinational ripple-carry adder,
// one word per cycle, LSW first. Define MWADD_OVF_EN to add the signed-overflow output ovf.
module mw_add_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] op_a,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] op_b,
  input  logic                            sub,
  output logic [DATA_WIDTH-1:0]           add_a,
  output logic [DATA_WIDTH-1:0]           add_b,
  output logic                            add_ci,
  input  logic [DATA_WIDTH-1:0]           add_s,
  input  logic                            add_co,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] sum,
  output logic                            carry_out
`ifdef MWADD_OVF_EN
  ,
  output logic                            ovf
`endif
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TOT_W = DATA_WIDTH * NUM_WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [TOT_W-1:0]     a_r;
  logic [TOT_W-1:0]     b_r;
  logic [TOT_W-1:0]     sum_r;
  logic                 sub_r;
  logic                 carry_r;
  logic [IDX_W-1:0]     idx_r;
  logic [DATA_WIDTH-1:0] a_word_s;
  logic [DATA_WIDTH-1:0] b_word_s;
  logic                 last_s;
  logic                 in_ready_s;
  logic                 out_valid_s;
  logic [DATA_WIDTH-1:0] add_a_s;
  logic [DATA_WIDTH-1:0] add_b_s;
  logic                 add_ci_s;

  assign a_word_s = a_r[int'(idx_r)*DATA_WIDTH +: DATA_WIDTH];
  assign b_word_s = b_r[int'(idx_r)*DATA_WIDTH +: DATA_WIDTH];
  assign last_s   = (idx_r == IDX_W'(NUM_WORDS - 1));

  // Next-state decode and adder/handshake drive; adder inputs are forced to zero outside RUN
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    add_a_s     = '0;
    add_b_s     = '0;
    add_ci_s    = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        add_a_s  = a_word_s;
        add_b_s  = sub_r ? ~b_word_s : b_word_s;
        add_ci_s = carry_r;
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        out_valid_s = 1'b1;
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Operand capture, word-serial sum collection and carry chaining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      idx_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= op_a;
            b_r     <= op_b;
            sub_r   <= sub;
            carry_r <= sub;
            idx_r   <= '0;
          end
        end
        RUN: begin
          sum_r[int'(idx_r)*DATA_WIDTH +: DATA_WIDTH] <= add_s;
          carry_r <= add_co;
          if (!last_s) idx_r <= idx_r + IDX_W'(1);
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

`ifdef MWADD_OVF_EN
  logic ovf_r;

  // Signed overflow from the MSBs of the final word, cleared when a new operation is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (state_r == IDLE && in_valid) begin
      ovf_r <= 1'b0;
    end else if (state_r == RUN && last_s) begin
      ovf_r <= (add_a_s[DATA_WIDTH-1] == add_b_s[DATA_WIDTH-1]) &&
               (add_s[DATA_WIDTH-1] != add_a_s[DATA_WIDTH-1]);
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign add_a     = add_a_s;
  assign add_b     = add_b_s;
  assign add_ci    = add_ci_s;
  assign sum       = sum_r;
  assign carry_out = carry_r;

endmodule
